// File: rtl/mem_arb_pkg.sv
// Types and constants shared by the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ARB_AW_DEFAULT = 32;
    localparam int unsigned ARB_DW_DEFAULT = 32;
    localparam int unsigned ARB_BEW        = 4;
    localparam int unsigned ARB_STARVE_W   = 4;

    localparam logic [ARB_BEW-1:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM stages, one transaction at a time.
// Optional grant/busy counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = ARB_AW_DEFAULT,
    parameter int unsigned DW         = ARB_DW_DEFAULT,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                i_req,
    input  logic [AW-1:0]       i_addr,
    output logic                i_ack,
    output logic [DW-1:0]       i_rdata,
    output logic                i_stall,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ARB_BEW-1:0]  d_be,
    input  logic [AW-1:0]       d_addr,
    input  logic [DW-1:0]       d_wdata,
    output logic                d_ack,
    output logic [DW-1:0]       d_rdata,
    output logic                d_stall,

    output logic                mem_req,
    output logic                mem_we,
    output logic [ARB_BEW-1:0]  mem_be,
    output logic [AW-1:0]       mem_addr,
    output logic [DW-1:0]       mem_wdata,
    input  logic                mem_ack,
    input  logic [DW-1:0]       mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_i_grants,
    output logic [31:0]         perf_d_grants,
    output logic [31:0]         perf_busy_cycles
`endif
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_LIMIT = ARB_STARVE_W'(STARVE_MAX);

    arb_state_e              state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ARB_BEW-1:0]      mem_be_q, mem_be_d;
    logic [AW-1:0]           mem_addr_q, mem_addr_d;
    logic [DW-1:0]           mem_wdata_q, mem_wdata_d;
    logic [ARB_STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    grant_i, grant_d;

    // Acks exist only while a transaction is outstanding; an ack in IDLE is dropped.
    assign i_ack   = mem_ack && (state_q == ARB_BUSY_I);
    assign d_ack   = mem_ack && (state_q == ARB_BUSY_D);
    assign i_rdata = i_ack ? mem_rdata : '0;
    assign d_rdata = (d_ack && !mem_we_q) ? mem_rdata : '0;
    assign i_stall = i_req && !i_ack;
    assign d_stall = d_req && !d_ack;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Arbitration and transaction sequencing.
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        starve_cnt_d = starve_cnt_q;
        grant_i      = 1'b0;
        grant_d      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // MEM holds the older instruction, so it wins unless IF has waited too long.
                grant_d = d_req && !(i_req && (starve_cnt_q == STARVE_LIMIT));
                grant_i = i_req && !grant_d;
                if (grant_d) begin
                    state_d     = ARB_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_req && (starve_cnt_q != STARVE_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + ARB_STARVE_W'(1);
                    end
                end else if (grant_i) begin
                    state_d      = ARB_BUSY_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = BE_ALL;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end else begin
                    mem_req_d = 1'b0;
                end
                if (!i_req) begin
                    starve_cnt_d = '0;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ack) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    // Free-running event counters; wrap naturally at 2^32.
    always_comb begin
        perf_i_d    = perf_i_q + 32'(grant_i);
        perf_d_d    = perf_d_q + 32'(grant_d);
        perf_busy_d = perf_busy_q + 32'(state_q != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_i_q    <= perf_i_d;
            perf_d_q    <= perf_d_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_i_grants    = perf_i_q;
    assign perf_d_grants    = perf_d_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter; one vector per clock cycle.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        ma;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        mreq;
        logic        mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        iack;
        logic [31:0] ird;
        logic        istl;
        logic        dack;
        logic [31:0] drd;
        logic        dstl;
    } out_t;

    typedef struct packed {
        logic [63:0] tag;
        in_t         stim;
        out_t        exp;
    } vec_t;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_stall;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_grants, perf_d_grants, perf_busy_cycles;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_i_grants    (perf_i_grants),
        .perf_d_grants    (perf_d_grants),
        .perf_busy_cycles (perf_busy_cycles)
`endif
    );

    function automatic in_t mi(logic rst, logic ir, logic [31:0] ia, logic dr, logic dwe,
                               logic [3:0] dbe, logic [31:0] da, logic [31:0] dwd,
                               logic ma, logic [31:0] mrd);
        return '{rst, ir, ia, dr, dwe, dbe, da, dwd, ma, mrd};
    endfunction

    function automatic out_t mo(logic mreq, logic mwe, logic [3:0] mbe, logic [31:0] maddr,
                                logic [31:0] mwd, logic iack, logic [31:0] ird, logic istl,
                                logic dack, logic [31:0] drd, logic dstl);
        return '{mreq, mwe, mbe, maddr, mwd, iack, ird, istl, dack, drd, dstl};
    endfunction

    function automatic out_t sample();
        return '{mem_req, mem_we, mem_be, mem_addr, mem_wdata,
                 i_ack, i_rdata, i_stall, d_ack, d_rdata, d_stall};
    endfunction

    task automatic add(input logic [63:0] tag, input in_t s, input out_t e);
        vecs.push_back('{tag, s, e});
    endtask

    task automatic drive(input in_t s);
        reset = s.rst; i_req = s.ir; i_addr = s.ia;
        d_req = s.dr; d_we = s.dwe; d_be = s.dbe; d_addr = s.da; d_wdata = s.dwd;
        mem_ack = s.ma; mem_rdata = s.mrd;
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are compared mid-cycle.
    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            out_t got;
            drive(vecs[k].stim);
            #3;
            got = sample();
            n_tests++;
            if (got !== vecs[k].exp) begin
                n_fail++;
                $display("FAIL vec %0d %s: got %h want %h", k, vecs[k].tag, got, vecs[k].exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int coll_end;
        int waited;

        reset = 1'b0; i_req = N; i_addr = '0; d_req = N; d_we = N; d_be = '0;
        d_addr = '0; d_wdata = '0; mem_ack = N; mem_rdata = '0;

        add("rst",   mi(Y,N,0,N,N,4'h0,0,0,N,0),                          mo(N,N,4'h0,0,0, N,0,N, N,0,N));
        // collision: D write wins, I follows one cycle after d_ack
        add("coll0", mi(Y,Y,32'h3008,Y,Y,4'h3,32'h10,32'hCAFEF00D,N,0),  mo(N,N,4'h0,0,0, N,0,Y, N,0,Y));
        add("coll1", mi(Y,Y,32'h3008,Y,Y,4'h3,32'h10,32'hCAFEF00D,N,0),  mo(Y,Y,4'h3,32'h10,32'hCAFEF00D, N,0,Y, N,0,Y));
        add("coll2", mi(Y,Y,32'h3008,Y,Y,4'h3,32'h10,32'hCAFEF00D,Y,32'h12345678),
                                                                         mo(Y,Y,4'h3,32'h10,32'hCAFEF00D, N,0,Y, Y,0,N));
        add("coll3", mi(Y,Y,32'h3008,N,N,4'h0,0,0,N,0),                   mo(N,Y,4'h3,32'h10,32'hCAFEF00D, N,0,Y, N,0,N));
        add("coll4", mi(Y,Y,32'h3008,N,N,4'h0,0,0,Y,32'hAAAA5555),        mo(Y,N,4'hF,32'h3008,0, Y,32'hAAAA5555,N, N,0,N));
        add("coll5", mi(Y,N,0,N,N,4'h0,0,0,N,0),                          mo(N,N,4'hF,32'h3008,0, N,0,N, N,0,N));
        coll_end = vecs.size();
        // single fetch, memory acks in the third mem_req cycle
        add("ftch0", mi(Y,Y,32'h3000,N,N,4'h0,0,0,N,0),                   mo(N,N,4'hF,32'h3008,0, N,0,Y, N,0,N));
        add("ftch1", mi(Y,Y,32'h3000,N,N,4'h0,0,0,N,0),                   mo(Y,N,4'hF,32'h3000,0, N,0,Y, N,0,N));
        add("ftch2", mi(Y,Y,32'h3000,N,N,4'h0,0,0,N,0),                   mo(Y,N,4'hF,32'h3000,0, N,0,Y, N,0,N));
        add("ftch3", mi(Y,Y,32'h3000,N,N,4'h0,0,0,Y,32'h20080005),        mo(Y,N,4'hF,32'h3000,0, Y,32'h20080005,N, N,0,N));
        add("ftch4", mi(Y,N,0,N,N,4'h0,0,0,N,0),                          mo(N,N,4'hF,32'h3000,0, N,0,N, N,0,N));
        add("spur0", mi(Y,N,0,N,N,4'h0,0,0,Y,32'hDEADBEEF),               mo(N,N,4'hF,32'h3000,0, N,0,N, N,0,N));
        add("spur1", mi(Y,N,0,N,N,4'h0,0,0,N,0),                          mo(N,N,4'hF,32'h3000,0, N,0,N, N,0,N));
        // starvation: four D grants while I waits, then I, then D again
        for (int g = 0; g < 4; g++) begin
            add("strvG", mi(Y,Y,32'h3010,Y,N,4'hF,32'h20,0,N,0),           mo(N,N,4'hF,(g == 0) ? 32'h3000 : 32'h20,0, N,0,Y, N,0,Y));
            add("strvA", mi(Y,Y,32'h3010,Y,N,4'hF,32'h20,0,Y,32'hD0+g),    mo(Y,N,4'hF,32'h20,0, N,0,Y, Y,32'hD0+g,N));
        end
        add("strvI0", mi(Y,Y,32'h3010,Y,N,4'hF,32'h20,0,N,0),             mo(N,N,4'hF,32'h20,0, N,0,Y, N,0,Y));
        add("strvI1", mi(Y,Y,32'h3010,Y,N,4'hF,32'h20,0,Y,32'h11110001),  mo(Y,N,4'hF,32'h3010,0, Y,32'h11110001,N, N,0,Y));
        add("strvD0", mi(Y,Y,32'h3010,Y,N,4'hF,32'h20,0,N,0),             mo(N,N,4'hF,32'h3010,0, N,0,Y, N,0,Y));
        add("strvD1", mi(Y,Y,32'h3010,Y,N,4'hF,32'h20,0,Y,32'hD5),        mo(Y,N,4'hF,32'h20,0, N,0,Y, Y,32'hD5,N));
        add("strvX",  mi(Y,N,0,N,N,4'h0,0,0,N,0),                         mo(N,N,4'hF,32'h20,0, N,0,N, N,0,N));
        // back-to-back fetch with zero-wait memory, address advanced on the ack cycle
        add("b2b0", mi(Y,Y,32'h3000,N,N,4'h0,0,0,N,0),                    mo(N,N,4'hF,32'h20,0, N,0,Y, N,0,N));
        add("b2b1", mi(Y,Y,32'h3004,N,N,4'h0,0,0,Y,32'h0000A000),         mo(Y,N,4'hF,32'h3000,0, Y,32'h0000A000,N, N,0,N));
        add("b2b2", mi(Y,Y,32'h3004,N,N,4'h0,0,0,N,0),                    mo(N,N,4'hF,32'h3000,0, N,0,Y, N,0,N));
        add("b2b3", mi(Y,Y,32'h3004,N,N,4'h0,0,0,Y,32'h0000A004),         mo(Y,N,4'hF,32'h3004,0, Y,32'h0000A004,N, N,0,N));
        add("b2b4", mi(Y,N,0,N,N,4'h0,0,0,N,0),                           mo(N,N,4'hF,32'h3004,0, N,0,N, N,0,N));

        repeat (2) @(posedge clk);
        #1;
        run_vecs(0, coll_end);
`ifdef MEM_ARB_PERF_EN
        check32("perf_i_grants", perf_i_grants, 32'd1);
        check32("perf_d_grants", perf_d_grants, 32'd1);
        check32("perf_busy_cycles", perf_busy_cycles, 32'd3);
`endif
        run_vecs(coll_end, vecs.size());

        // reset in the middle of a D write; the late mem_ack must be ignored
        d_req = Y; d_we = Y; d_be = 4'h5; d_addr = 32'h40; d_wdata = 32'h11223344;
        waited = 0;
        while (!mem_req && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check32("rmid_grant", 32'(mem_req), 32'd1);
        check32("rmid_addr", mem_addr, 32'h40);
        reset = 1'b0;
        #3;
        check32("rmid_noack", {30'b0, d_ack, i_ack}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1; d_req = N; d_we = N; d_be = '0; d_addr = '0; d_wdata = '0;
        #3;
        check32("rmid_clr_req", 32'(mem_req), 32'd0);
        check32("rmid_clr_addr", mem_addr, 32'd0);
        check32("rmid_clr_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_ack = Y; mem_rdata = 32'hFFFFFFFF;
        #3;
        check32("rmid_late_ack", {30'b0, d_ack, i_ack}, 32'd0);
        check32("rmid_late_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = N; mem_rdata = '0;
        #3;
        check32("rmid_idle_req", 32'(mem_req), 32'd0);
        i_req = Y; i_addr = 32'h3100;
        @(posedge clk);
        #1;
        check32("rmid_regrant", mem_addr, 32'h3100);
        check32("rmid_regrant_req", 32'(mem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
